// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive paths.
//   uart_state_e  - transmitter frame states
//   PAR_*         - encodings of the PARITY parameter
//   *_MIN/_MAX    - legal ranges for DATA_BITS and STOP_BITS
//   BIT_CNT_W     - width of a counter that can index any legal data bit
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    localparam int BIT_CNT_W = $clog2(DATA_BITS_MAX);

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between the bus-side logic and the transmitter.
//   in_valid - source has a byte in in_data
//   in_data  - payload, bit 0 sent first
//   in_ready - transmitter accepts the byte on this cycle
// A byte moves on every clk edge where in_valid and in_ready are both high.
// Modports: master = byte source, slave = transmitter.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
) ();

    logic                 in_valid;
    logic [DATA_BITS-1:0] in_data;
    logic                 in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/bclk_edge_detect.sv
// bclk_edge_detect: turns the baud-rate square wave into a one-clk pulse.
//   clk   - system clock, same domain as bclk
//   reset - asynchronous, active-high
//   bclk  - bit clock from the baud rate generator
//   tick  - high for one clk cycle after each bclk rising edge
module bclk_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic bclk,
    output logic tick
);

    logic bclk_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_q <= 1'b0;
        end else begin
            bclk_q <= bclk;
        end
    end

    assign tick = bclk & ~bclk_q;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: frames parallel bytes onto the serial line.
// Frame = start bit, DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits. Every bit boundary is a bclk rising edge.
//   clk    - system clock
//   reset  - asynchronous, active-high
//   bclk   - bit clock from the baud rate generator (one period per bit)
//   tx_bus - byte handshake (slave side): in_valid / in_data / in_ready
//   txd    - serial output, idle high
//   busy   - a frame has been accepted and is not yet complete
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     bclk,
    uart_tx_if.slave tx_bus,
    output logic     txd,
    output logic     busy
);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $fatal(1, "uart_tx: DATA_BITS=%0d outside %0d..%0d", DATA_BITS, DATA_BITS_MIN, DATA_BITS_MAX);
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
        $fatal(1, "uart_tx: PARITY=%0d not 0, 1 or 2", PARITY);
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $fatal(1, "uart_tx: STOP_BITS=%0d not 1 or 2", STOP_BITS);
    end

    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic                 LAST_STOP = 1'(STOP_BITS - 1);

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        logic p;
        p = ^d;
        return (PARITY == PAR_ODD) ? ~p : p;
    endfunction

    logic tick;

    bclk_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .bclk  (bclk),
        .tick  (tick)
    );

    uart_state_e          state_q, state_d;
    logic                 txd_q, txd_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 in_ready_q, busy_q;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            txd_q      <= 1'b1;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            txd_q      <= txd_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            // Decoded from the next state so the flags track state_q exactly.
            in_ready_q <= (state_d == ST_IDLE);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    // The payload registers are only meaningful once the FSM leaves IDLE,
    // which always reloads them, so they carry no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    always_comb begin
        state_d    = state_q;
        txd_d      = txd_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;

        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                // A tick coinciding with acceptance is deliberately ignored:
                // the start bit waits for the next full bit boundary.
                if (tx_bus.in_valid && in_ready_q) begin
                    shift_d = tx_bus.in_data;
                    par_d   = parity_bit(tx_bus.in_data);
                    state_d = ST_SYNC;
                end
            end

            ST_SYNC: begin
                if (tick) begin
                    txd_d   = 1'b0;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (tick) begin
                    txd_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end

            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        stop_cnt_d = 1'b0;
                        if (PARITY != PAR_NONE) begin
                            txd_d   = par_q;
                            state_d = ST_PARITY;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        txd_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            ST_PARITY: begin
                if (tick) begin
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = ST_STOP;
                end
            end

            ST_STOP: begin
                txd_d = 1'b1;
                if (tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                txd_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign txd             = txd_q;
    assign busy            = busy_q;
    assign tx_bus.in_ready = in_ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx in four configurations
// (8N1, 8E1, 8O1, 5N2) sharing one clk, reset and bclk
// (bclk = 4 clk high / 4 clk low, i.e. 8 clk per bit).
module tb_uart_tx;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic bclk = 1'b0;

    int ncyc      = 0;
    int rise_ncyc = 0;
    int n_chk     = 0;
    int n_pass    = 0;
    bit disturb_go = 1'b0;

    logic [3:0] valid_r;
    logic [7:0] data_r [4];
    logic       txd0, txd1, txd2, txd3;
    logic       busy0, busy1, busy2, busy3;
    logic [3:0] txd_w, busy_w, rdy_w;

    uart_tx_if #(.DATA_BITS(8)) if0 ();
    uart_tx_if #(.DATA_BITS(8)) if1 ();
    uart_tx_if #(.DATA_BITS(8)) if2 ();
    uart_tx_if #(.DATA_BITS(5)) if3 ();

    assign if0.in_valid = valid_r[0];
    assign if1.in_valid = valid_r[1];
    assign if2.in_valid = valid_r[2];
    assign if3.in_valid = valid_r[3];
    assign if0.in_data  = data_r[0];
    assign if1.in_data  = data_r[1];
    assign if2.in_data  = data_r[2];
    assign if3.in_data  = data_r[3][4:0];

    assign txd_w  = {txd3, txd2, txd1, txd0};
    assign busy_w = {busy3, busy2, busy1, busy0};
    assign rdy_w  = {if3.in_ready, if2.in_ready, if1.in_ready, if0.in_ready};

    uart_tx #(.DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset), .bclk(bclk), .tx_bus(if0), .txd(txd0), .busy(busy0));
    uart_tx #(.DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(reset), .bclk(bclk), .tx_bus(if1), .txd(txd1), .busy(busy1));
    uart_tx #(.DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .reset(reset), .bclk(bclk), .tx_bus(if2), .txd(txd2), .busy(busy2));
    uart_tx #(.DATA_BITS(5), .PARITY(PAR_NONE), .STOP_BITS(2)) u_5n2 (
        .clk(clk), .reset(reset), .bclk(bclk), .tx_bus(if3), .txd(txd3), .busy(busy3));

    initial forever #5 clk = ~clk;

    // bclk changes on falling clk edges; rise_ncyc remembers the falling
    // edge at which it last went high.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            ncyc++;
            cnt++;
            if (cnt == 4) begin
                cnt  = 0;
                bclk = ~bclk;
                if (bclk) rise_ncyc = ncyc;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Present a byte and wait for the accepting edge; returns at clk posedge + 1.
    task automatic send_byte(input int idx, input logic [7:0] d, input bit hold, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        valid_r[idx] = 1'b1;
        data_r[idx]  = d;
        while (n < 400) begin
            if (rdy_w[idx] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        if (!hold) valid_r[idx] = 1'b0;
    endtask

    // Wait for a start bit, then sample every bit at its first and last clk.
    task automatic capture(input int idx, input int nbits,
                           output logic [15:0] s0, output logic [15:0] s7,
                           output int rdy_after, output bit busy_ok,
                           output int edge_off, output int start_at);
        int n;
        s0 = '0; s7 = '0;
        rdy_after = -1; busy_ok = 1'b1; edge_off = -1; start_at = -1;
        n = 0;
        while (txd_w[idx] !== 1'b0 && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        if (txd_w[idx] !== 1'b0) return;
        edge_off = ncyc - rise_ncyc;
        start_at = ncyc;
        for (int o = 0; o < 8 * nbits; o++) begin
            if (o % 8 == 0) s0[o / 8] = txd_w[idx];
            if (o % 8 == 7) s7[o / 8] = txd_w[idx];
            if (busy_w[idx] !== 1'b1 || rdy_w[idx] !== 1'b0) busy_ok = 1'b0;
            @(negedge clk); #1;
        end
        n = 0;
        while (rdy_w[idx] !== 1'b1 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        if (rdy_w[idx] === 1'b1) rdy_after = 8 * nbits + n;
    endtask

    task automatic count_starts(input int idx, input int ncycles, output int falls);
        logic prev;
        falls = 0;
        prev  = txd_w[idx];
        for (int i = 0; i < ncycles; i++) begin
            @(negedge clk); #1;
            if (prev === 1'b1 && txd_w[idx] === 1'b0) falls++;
            prev = txd_w[idx];
        end
    endtask

    task automatic run_frame(input int idx, input int nbits, input logic [7:0] d,
                             input logic [15:0] exp_bits, input int exp_rdy, input string tag);
        bit          ok, bo;
        logic [15:0] s0, s7;
        int          ra, eo, st;
        send_byte(idx, d, 1'b0, ok);
        capture(idx, nbits, s0, s7, ra, bo, eo, st);
        chk({tag, "_accept"}, 32'(ok), 32'd1);
        chk({tag, "_edge"}, eo, 32'd1);
        chk({tag, "_bits_first"}, 32'(s0), 32'(exp_bits));
        chk({tag, "_bits_last"}, 32'(s7), 32'(exp_bits));
        chk({tag, "_ready_after"}, ra, exp_rdy);
        chk({tag, "_busy"}, 32'(bo), 32'd1);
    endtask

    // Wiggles in_data / in_valid of the 8N1 unit while it is busy.
    initial begin
        wait (disturb_go);
        repeat (12) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            #1;
            data_r[0]  = 8'hC3 ^ 8'(i);
            valid_r[0] = ~valid_r[0];
            repeat (5) @(negedge clk);
        end
        #1;
        valid_r[0] = 1'b0;
    end

    bit          ok1, ok2, bo_a, bo_b;
    logic [15:0] a0, a7, b0, b7;
    int          ra, rb, eo_a, eo_b, st_a, st_b, falls, n;

    initial begin
        reset   = 1'b1;
        valid_r = '0;
        for (int i = 0; i < 4; i++) data_r[i] = 8'h00;
        repeat (3) @(negedge clk); #1;
        chk("rst_txd", 32'(txd_w), 32'hF);
        chk("rst_ready", 32'(rdy_w), 32'hF);
        chk("rst_busy", 32'(busy_w), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk); #1;
        chk("idle_txd", 32'(txd_w), 32'hF);

        // start 0, data 1,0,1,0,1,0,1,0, stop 1
        run_frame(0, 10, 8'h55, 16'h02AA, 80, "n81_55");
        // data 1,1,0,0,0,1,0,1; even parity 0 / odd parity 1
        run_frame(1, 11, 8'hA3, 16'h0546, 88, "e81_A3");
        run_frame(2, 11, 8'hA3, 16'h0746, 88, "o81_A3");
        // start 0, five ones, two stop ones
        run_frame(3, 8, 8'h1F, 16'h00FE, 64, "n52_1F");

        // Back-to-back with in_valid held: 0x00 then 0xFF.
        send_byte(0, 8'h00, 1'b1, ok1);
        data_r[0] = 8'hFF;
        capture(0, 10, a0, a7, ra, bo_a, eo_a, st_a);
        send_byte(0, 8'hFF, 1'b0, ok2);
        capture(0, 10, b0, b7, rb, bo_b, eo_b, st_b);
        chk("b2b_first_bits", 32'(a0), 32'h0200);
        chk("b2b_first_ready", ra, 32'd80);
        chk("b2b_second_accept", 32'(ok2), 32'd1);
        chk("b2b_second_bits", 32'(b0), 32'h03FE);
        chk("b2b_second_bits_last", 32'(b7), 32'h03FE);
        chk("b2b_gap", st_b - st_a, 32'd88);
        count_starts(0, 40, falls);
        chk("b2b_frame_count", falls, 32'd0);

        // in_data / in_valid disturbed while busy: 0x3C must go out intact.
        send_byte(0, 8'h3C, 1'b0, ok1);
        disturb_go = 1'b1;
        capture(0, 10, a0, a7, ra, bo_a, eo_a, st_a);
        chk("hold_bits", 32'(a0), 32'h0278);
        chk("hold_bits_last", 32'(a7), 32'h0278);
        chk("hold_busy", 32'(bo_a), 32'd1);
        count_starts(0, 40, falls);
        chk("hold_no_extra", falls, 32'd0);

        // Reset in the middle of the data bits.
        send_byte(0, 8'h0F, 1'b0, ok1);
        n = 0;
        while (txd_w[0] !== 1'b0 && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        repeat (20) @(negedge clk); #1;
        chk("mid_busy", 32'(busy_w[0]), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_txd", 32'(txd_w[0]), 32'd1);
        chk("mid_rst_busy", 32'(busy_w[0]), 32'd0);
        chk("mid_rst_ready", 32'(rdy_w[0]), 32'd1);
        repeat (3) @(negedge clk); #1;
        reset = 1'b0;
        repeat (2) @(negedge clk); #1;
        // data 1,0,0,0,0,0,0,1
        run_frame(0, 10, 8'h81, 16'h0302, 80, "post_rst_81");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
